vector_lane_sequencer: RTL and testbench

Upstream/downstream companion to the 8-bit combinational vector ALU slice. Accepts a 32-bit packed vector operation (four 8-bit lanes of R and S plus a 5-bit ALU opcode) over a valid/ready handshake. Issues the lanes to the ALU slice one per cycle, lane 0 first, and captures each lane result. Presents the packed 32-bit result on a valid/ready output port.

---
 rtl/vector_pkg.sv | 32 +++
 rtl/vector_lane_sequencer.sv | 100 ++++++++++
 tb/tb_vector_lane_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector lane sequencer and its ALU slice.
package vector_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int OP_W   = 5;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES);

  localparam logic [OP_W-1:0] OP_ADD = 5'b01010;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } seq_state_t;

  // Request as captured at acceptance; held for the whole ISSUE phase.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [VEC_W-1:0] r;
    logic [VEC_W-1:0] s;
  } vec_req_t;

  function automatic logic [LANE_W-1:0] lane_sel(
    input logic [VEC_W-1:0] v,
    input logic [CNT_W-1:0] idx
  );
    return v[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/vector_lane_sequencer.sv
// Purpose: serialises a 4-lane vector op onto an 8-bit ALU slice, lane 0 first, and repacks the result.
// Latency: 4 cycles from accept to out_valid; one accept per 6 cycles minimum.
// Backpressure: in_ready only in IDLE; out_y/out_valid hold while out_ready is low.
module vector_lane_sequencer
  import vector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [VEC_W-1:0]  in_r,
  input  logic [VEC_W-1:0]  in_s,
  output logic [LANE_W-1:0] alu_r,
  output logic [LANE_W-1:0] alu_s,
  output logic [OP_W-1:0]   alu_op,
  input  logic [LANE_W-1:0] alu_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_y,
  output logic              busy
);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [CNT_W-1:0] lane_cnt_q;
  vec_req_t         req_q;
  logic [VEC_W-1:0] res_q;
  logic             last_lane;

  assign last_lane = (lane_cnt_q == CNT_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode only registered state, so reset forces them low immediately.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    alu_r     = '0;
    alu_s     = '0;
    alu_op    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy   = 1'b1;
        alu_r  = lane_sel(req_q.r, lane_cnt_q);
        alu_s  = lane_sel(req_q.s, lane_cnt_q);
        alu_op = req_q.op;
        if (last_lane) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane counter parks on the last lane when ISSUE ends; cleared at the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      lane_cnt_q <= '0;
      res_q      <= '0;
    end else if (state_q == IDLE && in_valid) begin
      req_q.op   <= in_op;
      req_q.r    <= in_r;
      req_q.s    <= in_s;
      lane_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      res_q[lane_cnt_q*LANE_W +: LANE_W] <= alu_y;
      if (!last_lane) begin
        lane_cnt_q <= lane_cnt_q + 1'b1;
      end
    end
  end

  assign out_y = res_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Self-checking bench for vector_lane_sequencer with a behavioural ALU slice attached.
module tb_vector_lane_sequencer;
  import vector_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [VEC_W-1:0]  in_r;
  logic [VEC_W-1:0]  in_s;
  logic [LANE_W-1:0] alu_r;
  logic [LANE_W-1:0] alu_s;
  logic [OP_W-1:0]   alu_op;
  logic [LANE_W-1:0] alu_y;
  logic              out_valid;
  logic              out_ready;
  logic [VEC_W-1:0]  out_y;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [4:0]  op;
    logic [31:0] r;
    logic [31:0] s;
    logic [31:0] y;
    string       name;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  // ALU slice: lane-wide add for OP_ADD, otherwise S passes through.
  always_comb begin
    alu_y = alu_s;
    if (alu_op == OP_ADD) alu_y = alu_r + alu_s;
  end

  vector_lane_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_r      (in_r),
    .in_s      (in_s),
    .alu_r     (alu_r),
    .alu_s     (alu_s),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents a request at #1 after an edge and returns #1 after its accept edge.
  task automatic accept(input logic [4:0] op, input logic [31:0] r, input logic [31:0] s,
                        input logic [31:0] y, input bit hold, output int waited);
    in_op    = op;
    in_r     = r;
    in_s     = s;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    sb.push_back(y);
    if (!hold) in_valid = 1'b0;
  endtask

  // Checks the lane presentation sequence and that out_valid appears exactly 4 cycles after accept.
  task automatic issue_check(input string name, input logic [4:0] op,
                             input logic [31:0] r, input logic [31:0] s);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_lane%0d_r", name, k), 32'(alu_r), 32'(r[8*k +: 8]));
      chk($sformatf("%s_lane%0d_s", name, k), 32'(alu_s), 32'(s[8*k +: 8]));
      chk($sformatf("%s_lane%0d_op", name, k), 32'(alu_op), 32'(op));
      chk($sformatf("%s_lane%0d_novalid", name, k), 32'(out_valid), 32'd0);
      chk($sformatf("%s_lane%0d_busy", name, k), 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    chk({name, "_latency4"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_out(input string name);
    if (sb.size() == 0) chk({name, "_sb_empty"}, 32'd1, 32'd0);
    else chk({name, "_out_y"}, out_y, sb.pop_front());
  endtask

  initial begin
    int w;

    tbl[0] = '{5'b01010, 32'h01020304, 32'h10203040, 32'h11223344, "add"};
    tbl[1] = '{5'b01010, 32'hFFFF80FF, 32'h01018001, 32'h00000000, "lane_wrap"};
    tbl[2] = '{5'b00000, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, "default_op"};
    tbl[3] = '{5'b01011, 32'hAAAAAAAA, 32'hCAFEF00D, 32'hCAFEF00D, "near_add_op"};
    tbl[4] = '{5'b01010, 32'h7F7F7F7F, 32'h01010101, 32'h80808080, "add_msb"};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_r      = '0;
    in_s      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu", {19'd0, alu_op, alu_r}, 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      accept(tbl[i].op, tbl[i].r, tbl[i].s, tbl[i].y, 1'b0, w);
      issue_check(tbl[i].name, tbl[i].op, tbl[i].r, tbl[i].s);
      check_out(tbl[i].name);
      chk({tbl[i].name, "_done_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk({tbl[i].name, "_handoff_in_ready"}, 32'(in_ready), 32'd1);
      chk({tbl[i].name, "_handoff_out_valid"}, 32'(out_valid), 32'd0);
    end

    // Backpressure: result must hold for 3 stalled cycles, then next accept right after handoff.
    out_ready = 1'b0;
    accept(5'b01010, 32'h01020304, 32'h10203040, 32'h11223344, 1'b0, w);
    issue_check("bp", 5'b01010, 32'h01020304, 32'h10203040);
    check_out("bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_y", i), out_y, 32'h11223344);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    accept(5'b00000, 32'h0, 32'h55AA33CC, 32'h55AA33CC, 1'b0, w);
    chk("bp_next_accept_wait", 32'(w), 32'd0);
    issue_check("bp_next", 5'b00000, 32'h0, 32'h55AA33CC);
    check_out("bp_next");
    @(posedge clk); #1;

    // Asynchronous reset while lane 2 is on the ALU.
    accept(5'b01010, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_lane2_r", 32'(alu_r), 32'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu", {19'd0, alu_op, alu_r}, 32'd0);
    chk("mid_rst_alu_s", 32'(alu_s), 32'd0);
    chk("mid_rst_out_y", out_y, 32'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    accept(5'b01010, 32'h01010101, 32'h01010101, 32'h02020202, 1'b0, w);
    issue_check("post_rst", 5'b01010, 32'h01010101, 32'h01010101);
    check_out("post_rst");
    @(posedge clk); #1;

    // Back-to-back: in_valid stays high; B only accepted one edge after A's handoff.
    accept(5'b01010, 32'h0A0B0C0D, 32'h01010101, 32'h0B0C0D0E, 1'b1, w);
    in_r = 32'h00000000;
    in_s = 32'hF00DBABE;
    in_op = 5'b00001;
    issue_check("b2b_a", 5'b01010, 32'h0A0B0C0D, 32'h01010101);
    check_out("b2b_a");
    @(posedge clk); #1;
    chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b_b_accepted", 32'(busy), 32'd1);
    sb.push_back(32'hF00DBABE);
    in_valid = 1'b0;
    issue_check("b2b_b", 5'b00001, 32'h00000000, 32'hF00DBABE);
    check_out("b2b_b");
    @(posedge clk); #1;
    chk("b2b_end_in_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
